// File: rtl/bpu_gshare_btb.sv
// Fetch-stage branch predictor: gshare direction table plus tagged direct-mapped BTB.
// Optional return-address stack is compiled in with `define BPU_RAS_EN.
module bpu_gshare_btb #(
   parameter int BHT_IDX_W = 8,
   parameter int BTB_IDX_W = 5,
   parameter int TAG_W     = 8,
   parameter int RAS_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_fetch_valid,
   input  logic [31:0]          i_fetch_pc,
   output logic                 o_pred_taken,
   output logic [31:0]          o_pred_target,
   output logic [BHT_IDX_W-1:0] o_pred_ghr,
   input  logic                 i_upd_valid,
   input  logic [31:0]          i_upd_pc,
   input  logic                 i_upd_taken,
   input  logic [31:0]          i_upd_target,
   input  logic [BHT_IDX_W-1:0] i_upd_ghr,
   input  logic                 i_upd_mispredict,
   input  logic                 i_upd_is_call,
   input  logic                 i_upd_is_ret
);
   localparam int BHT_N = 1 << BHT_IDX_W;
   localparam int BTB_N = 1 << BTB_IDX_W;

   logic [1:0]           r_ctr        [BHT_N];
   logic [BTB_N-1:0]     r_btb_valid;
   logic [TAG_W-1:0]     r_btb_tag    [BTB_N];
   logic [31:0]          r_btb_target [BTB_N];
   logic [BHT_IDX_W-1:0] r_ghr;

   logic [BHT_IDX_W-1:0] w_bht_idx;
   logic [BTB_IDX_W-1:0] w_bi;
   logic [TAG_W-1:0]     w_tag;
   logic                 w_hit;
   logic [31:0]          w_pc_plus4;
   logic [BHT_IDX_W-1:0] w_upd_bht_idx;
   logic [BTB_IDX_W-1:0] w_upd_bi;
   logic [TAG_W-1:0]     w_upd_tag;
   logic                 w_pred_taken;
   logic [31:0]          w_pred_target;
   logic                 w_unused;

   assign w_bht_idx     = i_fetch_pc[BHT_IDX_W+1:2] ^ r_ghr;
   assign w_bi          = i_fetch_pc[BTB_IDX_W+1:2];
   assign w_tag         = i_fetch_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
   assign w_hit         = r_btb_valid[w_bi] && (r_btb_tag[w_bi] == w_tag);
   assign w_pc_plus4    = i_fetch_pc + 32'd4;
   assign w_upd_bht_idx = i_upd_pc[BHT_IDX_W+1:2] ^ i_upd_ghr;
   assign w_upd_bi      = i_upd_pc[BTB_IDX_W+1:2];
   assign w_upd_tag     = i_upd_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];

`ifdef BPU_RAS_EN
   localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
   localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

   logic [BTB_N-1:0]     r_btb_call;
   logic [BTB_N-1:0]     r_btb_ret;
   logic [31:0]          r_ras [RAS_DEPTH];
   logic [RAS_PTR_W-1:0] r_ras_ptr;
   logic [RAS_CNT_W-1:0] r_ras_cnt;
   logic [RAS_PTR_W-1:0] w_ras_top;
   logic                 w_ras_pop;
   logic                 w_ras_push;

   // r_ras_ptr is the next free slot; the top of stack sits one below it.
   assign w_ras_top  = r_ras_ptr - RAS_PTR_W'(1);
   assign w_ras_pop  = i_fetch_valid && w_hit && r_btb_ret[w_bi];
   assign w_ras_push = i_fetch_valid && w_hit && r_btb_call[w_bi] && !r_btb_ret[w_bi] && w_pred_taken;
   assign w_unused   = ^{i_upd_pc[31:BTB_IDX_W+TAG_W+2], i_upd_pc[1:0]};
`else
   assign w_unused   = ^{i_upd_pc[31:BTB_IDX_W+TAG_W+2], i_upd_pc[1:0], i_upd_is_call, i_upd_is_ret};
`endif

   always_comb begin
      w_pred_taken  = w_hit && r_ctr[w_bht_idx][1];
      w_pred_target = w_pred_taken ? r_btb_target[w_bi] : w_pc_plus4;
`ifdef BPU_RAS_EN
      if (w_hit && r_btb_ret[w_bi]) begin
         w_pred_taken  = 1'b1;
         w_pred_target = (r_ras_cnt != '0) ? r_ras[w_ras_top] : r_btb_target[w_bi];
      end
`endif
   end

   assign o_pred_taken  = w_pred_taken;
   assign o_pred_target = w_pred_target;
   assign o_pred_ghr    = r_ghr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_N; i++) r_ctr[i] <= 2'b01;
      end else if (i_upd_valid) begin
         if (i_upd_taken && r_ctr[w_upd_bht_idx] != 2'b11)
            r_ctr[w_upd_bht_idx] <= r_ctr[w_upd_bht_idx] + 2'd1;
         else if (!i_upd_taken && r_ctr[w_upd_bht_idx] != 2'b00)
            r_ctr[w_upd_bht_idx] <= r_ctr[w_upd_bht_idx] - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_btb_valid <= '0;
      else if (i_upd_valid && i_upd_taken)
         r_btb_valid[w_upd_bi] <= 1'b1;
   end

   // Payload is qualified by the valid bits, so it carries no reset.
   always_ff @(posedge clk) begin
      if (rst_n && i_upd_valid && i_upd_taken) begin
         r_btb_tag[w_upd_bi]    <= w_upd_tag;
         r_btb_target[w_upd_bi] <= i_upd_target;
`ifdef BPU_RAS_EN
         r_btb_call[w_upd_bi]   <= i_upd_is_call;
         r_btb_ret[w_upd_bi]    <= i_upd_is_ret;
`endif
      end
   end

   // Mispredict repair wins over the speculative fetch shift.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_ghr <= '0;
      else if (i_upd_valid && i_upd_mispredict)
         r_ghr <= {i_upd_ghr[BHT_IDX_W-2:0], i_upd_taken};
      else if (i_fetch_valid && w_hit)
         r_ghr <= {r_ghr[BHT_IDX_W-2:0], w_pred_taken};
   end

`ifdef BPU_RAS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ras_ptr <= '0;
         r_ras_cnt <= '0;
      end else if (w_ras_pop) begin
         if (r_ras_cnt != '0) begin
            r_ras_ptr <= w_ras_top;
            r_ras_cnt <= r_ras_cnt - RAS_CNT_W'(1);
         end
      end else if (w_ras_push) begin
         r_ras_ptr <= r_ras_ptr + RAS_PTR_W'(1);
         if (r_ras_cnt != RAS_CNT_W'(RAS_DEPTH))
            r_ras_cnt <= r_ras_cnt + RAS_CNT_W'(1);
      end
   end

   // Circular stack: a push when full overwrites the oldest slot.
   always_ff @(posedge clk) begin
      if (rst_n && !w_ras_pop && w_ras_push)
         r_ras[r_ras_ptr] <= w_pc_plus4;
   end
`endif
endmodule

// File: tb/tb_bpu_gshare_btb.sv
// Bench for bpu_gshare_btb: directed vector table, randomized run against an
// array/queue reference model, mid-run reset, and return-stack sequences.
module tb_bpu_gshare_btb;
   localparam int RAS_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        o_pred_taken;
   logic [31:0] o_pred_target;
   logic [7:0]  o_pred_ghr;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [7:0]  upd_ghr;
   logic        upd_mispredict;
   logic        upd_is_call;
   logic        upd_is_ret;

   always #5 clk = ~clk;

   bpu_gshare_btb #(.BHT_IDX_W(8), .BTB_IDX_W(5), .TAG_W(8), .RAS_DEPTH(RAS_DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_fetch_valid    (fetch_valid),
      .i_fetch_pc       (fetch_pc),
      .o_pred_taken     (o_pred_taken),
      .o_pred_target    (o_pred_target),
      .o_pred_ghr       (o_pred_ghr),
      .i_upd_valid      (upd_valid),
      .i_upd_pc         (upd_pc),
      .i_upd_taken      (upd_taken),
      .i_upd_target     (upd_target),
      .i_upd_ghr        (upd_ghr),
      .i_upd_mispredict (upd_mispredict),
      .i_upd_is_call    (upd_is_call),
      .i_upd_is_ret     (upd_is_ret)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: plain arrays indexed by arithmetic on the PCs.
   int          m_ctr  [256];
   bit          m_valid[32];
   logic [7:0]  m_tag  [32];
   logic [31:0] m_tgt  [32];
   bit          m_call [32];
   bit          m_ret  [32];
   logic [7:0]  m_ghr;
   logic [31:0] ras_q[$];
   logic [31:0] exp_q[$];

   typedef struct {
      logic        fv;
      logic [31:0] fpc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic [7:0]  ughr;
      logic        um;
      logic        etk;
      logic [31:0] etgt;
      logic [7:0]  eghr;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 256; i++) m_ctr[i] = 1;
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_call[i]  = 1'b0;
         m_ret[i]   = 1'b0;
      end
      m_ghr = '0;
      ras_q.delete();
   endfunction

   function automatic int m_bi(input logic [31:0] pc);
      return int'((pc >> 2) % 32);
   endfunction

   function automatic logic m_hit();
      int bi = m_bi(fetch_pc);
      return m_valid[bi] && (m_tag[bi] == 8'((fetch_pc >> 7) % 256));
   endfunction

   function automatic logic m_taken();
      int bi = m_bi(fetch_pc);
      int hi = int'(((fetch_pc >> 2) % 256) ^ 32'(m_ghr));
      logic tk = m_hit() && (m_ctr[hi] >= 2);
`ifdef BPU_RAS_EN
      if (m_hit() && m_ret[bi]) tk = 1'b1;
`endif
      return tk;
   endfunction

   function automatic logic [31:0] m_target();
      int bi = m_bi(fetch_pc);
      logic [31:0] tgt = m_taken() ? m_tgt[bi] : fetch_pc + 32'd4;
`ifdef BPU_RAS_EN
      if (m_hit() && m_ret[bi]) tgt = (ras_q.size() > 0) ? ras_q[$] : m_tgt[bi];
`endif
      return tgt;
   endfunction

   // Advance the model across one clock edge from the current inputs.
   function automatic void m_update();
      int ui;
      int ubi;
      logic tk;
      if (!rst_n) begin
         m_reset();
         return;
      end
      tk = m_taken();
`ifdef BPU_RAS_EN
      if (fetch_valid && m_hit() && m_ret[m_bi(fetch_pc)]) begin
         if (ras_q.size() > 0) void'(ras_q.pop_back());
      end else if (fetch_valid && m_hit() && m_call[m_bi(fetch_pc)] && tk) begin
         ras_q.push_back(fetch_pc + 32'd4);
         if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
      end
`endif
      if (upd_valid && upd_mispredict) m_ghr = 8'((upd_ghr << 1) | 8'(upd_taken));
      else if (fetch_valid && m_hit()) m_ghr = 8'((m_ghr << 1) | 8'(tk));
      if (upd_valid) begin
         ui = int'(((upd_pc >> 2) % 256) ^ 32'(upd_ghr));
         if (upd_taken) begin
            if (m_ctr[ui] < 3) m_ctr[ui]++;
            ubi          = m_bi(upd_pc);
            m_valid[ubi] = 1'b1;
            m_tag[ubi]   = 8'((upd_pc >> 7) % 256);
            m_tgt[ubi]   = upd_target;
            m_call[ubi]  = upd_is_call;
            m_ret[ubi]   = upd_is_ret;
         end else if (m_ctr[ui] > 0) begin
            m_ctr[ui]--;
         end
      end
   endfunction

   // Called at a negedge with inputs applied; checks, clocks, returns at the next negedge.
   task automatic step(input bit use_tbl, input logic etk, input logic [31:0] etgt,
                       input logic [7:0] eghr, input string name);
      #1;
      if (use_tbl) begin
         check({name, "_taken"},  32'(o_pred_taken), 32'(etk));
         check({name, "_target"}, o_pred_target,     etgt);
         check({name, "_ghr"},    32'(o_pred_ghr),   32'(eghr));
      end else begin
         check({name, "_taken"},  32'(o_pred_taken), 32'(m_taken()));
         check({name, "_target"}, o_pred_target,     m_target());
         check({name, "_ghr"},    32'(o_pred_ghr),   32'(m_ghr));
      end
      m_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      fetch_valid    = 1'b0;
      fetch_pc       = '0;
      upd_valid      = 1'b0;
      upd_pc         = '0;
      upd_taken      = 1'b0;
      upd_target     = '0;
      upd_ghr        = '0;
      upd_mispredict = 1'b0;
      upd_is_call    = 1'b0;
      upd_is_ret     = 1'b0;
   endtask

   task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic call, input logic ret);
      idle();
      upd_valid   = 1'b1;
      upd_pc      = pc;
      upd_taken   = 1'b1;
      upd_target  = tgt;
      upd_is_call = call;
      upd_is_ret  = ret;
      step(0, 0, 0, 0, "train");
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step(0, 0, 0, 0, "rst");
      rst_n = 1'b1;
   endtask

   initial begin
      // fv, fpc, uv, upc, ut, utgt, ughr, um, exp taken, exp target, exp ghr
      vecs[0]  = '{1'b1, 32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b0, 32'h104,  8'h00};
      vecs[1]  = '{1'b0, 32'h100,      1'b1, 32'h100, 1'b1, 32'h200, 8'h00, 1'b0, 1'b0, 32'h104,  8'h00};
      vecs[2]  = '{1'b1, 32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 32'h200,  8'h00};
      vecs[3]  = '{1'b0, 32'h100,      1'b1, 32'h100, 1'b1, 32'h200, 8'h00, 1'b0, 1'b0, 32'h104,  8'h01};
      vecs[4]  = '{1'b0, 32'h100,      1'b1, 32'h100, 1'b1, 32'h200, 8'h00, 1'b0, 1'b0, 32'h104,  8'h01};
      vecs[5]  = '{1'b0, 32'h100,      1'b1, 32'h100, 1'b1, 32'h200, 8'h00, 1'b0, 1'b0, 32'h104,  8'h01};
      vecs[6]  = '{1'b0, 32'h100,      1'b1, 32'h100, 1'b0, 32'h0,   8'h80, 1'b1, 1'b0, 32'h104,  8'h01};
      vecs[7]  = '{1'b0, 32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 32'h200,  8'h00};
      vecs[8]  = '{1'b0, 32'h100,      1'b1, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 32'h200,  8'h00};
      vecs[9]  = '{1'b0, 32'h100,      1'b1, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 32'h200,  8'h00};
      vecs[10] = '{1'b0, 32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b0, 32'h104,  8'h00};
      vecs[11] = '{1'b1, 32'h2100,     1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b0, 32'h2104, 8'h00};
      vecs[12] = '{1'b0, 32'h2100,     1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b0, 32'h2104, 8'h00};
      vecs[13] = '{1'b0, 32'h100,      1'b1, 32'h100, 1'b1, 32'h200, 8'h00, 1'b0, 1'b0, 32'h104,  8'h00};
      vecs[14] = '{1'b1, 32'h100,      1'b1, 32'h500, 1'b0, 32'h0,   8'h0F, 1'b1, 1'b1, 32'h200,  8'h00};
      vecs[15] = '{1'b0, 32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b0, 32'h104,  8'h1E};
      vecs[16] = '{1'b0, 32'hFFFFFFFC, 1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b0, 32'h0,    8'h1E};
      vecs[17] = '{1'b1, 32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b0, 32'h104,  8'h1E};
      vecs[18] = '{1'b0, 32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b0, 32'h104,  8'h3C};

      idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();

      for (int i = 0; i < NV; i++) begin
         fetch_valid    = vecs[i].fv;
         fetch_pc       = vecs[i].fpc;
         upd_valid      = vecs[i].uv;
         upd_pc         = vecs[i].upc;
         upd_taken      = vecs[i].ut;
         upd_target     = vecs[i].utgt;
         upd_ghr        = vecs[i].ughr;
         upd_mispredict = vecs[i].um;
         upd_is_call    = 1'b0;
         upd_is_ret     = 1'b0;
         step(1, vecs[i].etk, vecs[i].etgt, vecs[i].eghr, $sformatf("vec%0d", i));
      end

      // Small PC pool so tags alias, entries get retrained and same-cycle conflicts occur.
      for (int n = 0; n < 1500; n++) begin
         fetch_valid    = 1'($urandom_range(0, 1));
         fetch_pc       = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 15)) << 2);
         upd_valid      = ($urandom_range(0, 2) != 0);
         upd_pc         = ($urandom_range(0, 7) == 0) ? fetch_pc
                          : (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 15)) << 2);
         upd_taken      = 1'($urandom_range(0, 1));
         upd_target     = $urandom;
         upd_ghr        = ($urandom_range(0, 1) != 0) ? m_ghr : 8'($urandom_range(0, 255));
         upd_mispredict = ($urandom_range(0, 3) == 0);
         upd_is_call    = ($urandom_range(0, 7) == 0);
         upd_is_ret     = ($urandom_range(0, 7) == 0);
         step(0, 0, 0, 0, "rnd");
      end

      // Reset mid-run with a taken update pending: the update must be lost.
      fetch_valid    = 1'b1;
      fetch_pc       = 32'h100;
      upd_valid      = 1'b1;
      upd_pc         = 32'h100;
      upd_taken      = 1'b1;
      upd_target     = 32'h777;
      upd_mispredict = 1'b1;
      rst_n          = 1'b0;
      step(0, 0, 0, 0, "midrst");
      rst_n = 1'b1;
      idle();
      fetch_valid = 1'b1;
      fetch_pc    = 32'h100;
      step(1, 1'b0, 32'h104, 8'h00, "post_rst");

`ifdef BPU_RAS_EN
      do_reset();
      train(32'h300, 32'h1010, 1'b1, 1'b0);
      train(32'h1010, 32'h5000, 1'b0, 1'b1);
      idle();
      fetch_valid = 1'b1;
      fetch_pc    = 32'h300;
      step(1, 1'b1, 32'h1010, 8'h00, "ras_call");
      fetch_pc    = 32'h1010;
      step(1, 1'b1, 32'h304, 8'h01, "ras_ret");

      do_reset();
      for (int k = 0; k < 9; k++) train(32'h400 + 32'(4 * k), 32'h1040, 1'b1, 1'b0);
      train(32'h1040, 32'h5000, 1'b0, 1'b1);
      // Each call fetch is paired with a repair to GHR 0 so every call stays predicted taken.
      for (int k = 0; k < 9; k++) begin
         idle();
         fetch_valid    = 1'b1;
         fetch_pc       = 32'h400 + 32'(4 * k);
         upd_valid      = 1'b1;
         upd_pc         = 32'h3F0;
         upd_mispredict = 1'b1;
         step(0, 0, 0, 0, "ras_push");
      end
      for (int k = 8; k >= 1; k--) exp_q.push_back(32'h404 + 32'(4 * k));
      exp_q.push_back(32'h5000);
      while (exp_q.size() > 0) begin
         idle();
         fetch_valid = 1'b1;
         fetch_pc    = 32'h1040;
         #1;
         check("ras_pop", o_pred_target, exp_q.pop_front());
         step(0, 0, 0, 0, "ras_popm");
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
